// File: rtl/spu_pkg.sv
// Shared SPU constants: register file geometry and execution latencies
// used by the issue scoreboard.
package spu_pkg;

  localparam int unsigned NumRegs = 128;
  localparam int unsigned RegW    = 7;
  localparam int unsigned LatW    = 3;

  // Result latencies in cycles from issue to writeback.
  localparam int unsigned LatLoad  = 6;
  localparam int unsigned LatFixed = 2;
  localparam int unsigned LatFloat = 6;

  // Bit positions of each source in the src_used vector.
  typedef enum logic [1:0] {
    SrcRa = 2'd0,
    SrcRb = 2'd1,
    SrcRc = 2'd2
  } src_sel_e;

  localparam int unsigned NumSrcs = 3;

endpackage

// File: rtl/spu_sb_entry.sv
// One scoreboard entry: a latency countdown that reloads on issue and
// otherwise counts down to zero; nonzero means the register is in flight.
module spu_sb_entry
  import spu_pkg::*;
#(
  parameter int unsigned LAT_W = LatW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] count,
  output logic             pending
);

  logic [LAT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign pending = (count_q != '0);

endmodule

// File: rtl/spu_scoreboard.sv
// Issue-stage register scoreboard: detects RAW/WAW hazards against in-flight
// results, generates stall/accept/bubble, and reports the in-flight count.
module spu_scoreboard
  import spu_pkg::*;
#(
  parameter int unsigned NUM_REGS = NumRegs,
  parameter int unsigned LAT_W    = LatW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic             issue_regwrite,
  input  logic [RegW-1:0]  issue_dest,
  input  logic [LAT_W-1:0] issue_latency,
  input  logic [RegW-1:0]  src_ra,
  input  logic [RegW-1:0]  src_rb,
  input  logic [RegW-1:0]  src_rc,
  input  logic [2:0]       src_used,
  input  logic             flush,
  output logic             stall,
  output logic             idex_bubble,
  output logic             issue_accept,
  output logic [7:0]       pending_count
);

  logic [LAT_W-1:0]    count [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] load;
  logic [RegW-1:0]     srcs [NumSrcs];
  logic [LAT_W-1:0]    dest_count;
  logic                dest_in_range;
  logic                writes_reg;
  logic                raw_hit;
  logic                waw_hit;
  logic                present;
  logic [7:0]          pop;
  logic [7:0]          pending_count_q;

  assign srcs[SrcRa] = src_ra;
  assign srcs[SrcRb] = src_rb;
  assign srcs[SrcRc] = src_rc;

  assign dest_in_range = (32'(issue_dest) < NUM_REGS);
  assign writes_reg    = issue_regwrite && (issue_latency != '0);

  always_comb begin
    dest_count = '0;
    if (dest_in_range) begin
      dest_count = count[issue_dest];
    end
  end

  // Hazards read the pre-update countdowns only, so an instruction never
  // sees its own destination load.
  always_comb begin
    raw_hit = 1'b0;
    for (int s = 0; s < NumSrcs; s++) begin
      if (src_used[s] && (32'(srcs[s]) < NUM_REGS) && pending[srcs[s]]) begin
        raw_hit = 1'b1;
      end
    end
  end

  assign waw_hit = writes_reg && (dest_count > issue_latency);

  // Gating with reset holds the stage in bubble while reset is asserted.
  assign present      = reset && issue_valid && !flush;
  assign stall        = present && (raw_hit || waw_hit);
  assign issue_accept = present && !(raw_hit || waw_hit);
  assign idex_bubble  = !issue_accept;

  always_comb begin
    load = '0;
    if (issue_accept && writes_reg && dest_in_range) begin
      load[issue_dest] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
    spu_sb_entry #(
      .LAT_W(LAT_W)
    ) u_entry (
      .clk     (clk),
      .reset   (reset),
      .load    (load[i]),
      .load_val(issue_latency),
      .count   (count[i]),
      .pending (pending[i])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pop = pop + 8'(pending[i]);
    end
  end

  // Registered popcount of the countdowns, trailing their update by a cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_count_q <= '0;
    end else begin
      pending_count_q <= pop;
    end
  end

  assign pending_count = pending_count_q;

endmodule
